// File: rtl/branch_ctrl_if.sv
// EX-stage to branch controller bus: resolution inputs, redirect/flush/exception
// outputs and performance counters, with master (pipeline) and slave (controller) views.
interface branch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid_i;
    logic [6:0]       ex_opcode_i;
    logic [31:0]      ex_pc_i;
    logic [31:0]      ex_imm_i;
    logic [31:0]      ex_rs1_i;
    logic             branch_condition_i;
    logic             stall_i;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             flush_o;
    logic             ex_kill_o;
    logic             misalign_exc_o;
    logic [31:0]      misalign_addr_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] taken_cnt_o;

    modport master (
        output ex_valid_i, ex_opcode_i, ex_pc_i, ex_imm_i, ex_rs1_i,
               branch_condition_i, stall_i,
        input  redirect_o, redirect_pc_o, flush_o, ex_kill_o,
               misalign_exc_o, misalign_addr_o, branch_cnt_o, taken_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_opcode_i, ex_pc_i, ex_imm_i, ex_rs1_i,
               branch_condition_i, stall_i,
        output redirect_o, redirect_pc_o, flush_o, ex_kill_o,
               misalign_exc_o, misalign_addr_o, branch_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution controller: resolves taken branch/JAL/JALR in EX into a redirect or a
// misaligned-target exception. Define BRANCH_PERF_EN to add resolved/taken counters.
module branch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    branch_ctrl_if.slave  bus,
    output logic [1:0]    dbg_state
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        EXC      = 2'd2
    } state_t;

    state_t      state;
    logic        redirect_q;
    logic        flush_q;
    logic        kill_q;
    logic        exc_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] misalign_addr_q;

    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        taken;
    logic        accept;
    logic [31:0] jalr_sum;
    logic [31:0] target;

    assign is_branch = (bus.ex_opcode_i == OP_BRANCH);
    assign is_jal    = (bus.ex_opcode_i == OP_JAL);
    assign is_jalr   = (bus.ex_opcode_i == OP_JALR);
    assign taken     = (is_branch && bus.branch_condition_i) || is_jal || is_jalr;

    // Handshake: an EX instruction is consumed when ex_valid_i=1 and stall_i=0 while IDLE;
    // stall_i acts as not-ready, and in REDIRECT it also holds the pending redirect.
    assign accept    = (state == IDLE) && bus.ex_valid_i && !bus.stall_i;

    assign jalr_sum  = bus.ex_rs1_i + bus.ex_imm_i;
    assign target    = is_jalr ? {jalr_sum[31:1], 1'b0} : (bus.ex_pc_i + bus.ex_imm_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            redirect_q      <= 1'b0;
            flush_q         <= 1'b0;
            kill_q          <= 1'b0;
            exc_q           <= 1'b0;
            redirect_pc_q   <= 32'h0;
            misalign_addr_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && taken) begin
                        flush_q <= 1'b1;
                        kill_q  <= 1'b1;
                        if (!target[1]) begin
                            state         <= REDIRECT;
                            redirect_q    <= 1'b1;
                            redirect_pc_q <= target;
                        end else begin
                            state           <= EXC;
                            exc_q           <= 1'b1;
                            misalign_addr_q <= target;
                        end
                    end
                end
                REDIRECT: begin
                    // Fetch cannot take the redirect while stalled, so keep presenting it.
                    if (!bus.stall_i) begin
                        state      <= IDLE;
                        redirect_q <= 1'b0;
                        flush_q    <= 1'b0;
                        kill_q     <= 1'b0;
                    end
                end
                EXC: begin
                    state   <= IDLE;
                    exc_q   <= 1'b0;
                    flush_q <= 1'b0;
                    kill_q  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                    kill_q     <= 1'b0;
                    exc_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect_o      = redirect_q;
    assign bus.redirect_pc_o   = redirect_pc_q;
    assign bus.flush_o         = flush_q;
    assign bus.ex_kill_o       = kill_q;
    assign bus.misalign_exc_o  = exc_q;
    assign bus.misalign_addr_o = misalign_addr_q;
    assign dbg_state           = state;

`ifdef BRANCH_PERF_EN
    logic             is_ctrl;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    assign is_ctrl = is_branch || is_jal || is_jalr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (accept) begin
            if (is_ctrl) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (taken)   taken_cnt_q  <= taken_cnt_q + 1'b1;
        end
    end

    assign bus.branch_cnt_o = branch_cnt_q;
    assign bus.taken_cnt_o  = taken_cnt_q;
`else
    assign bus.branch_cnt_o = {CNT_W{1'b0}};
    assign bus.taken_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized scoreboard bench for branch_ctrl: a driver pushes expected redirect/exception
// events, a negedge monitor pops and compares them and checks idle/reset/counter behaviour.
module tb_branch_ctrl;
    localparam int CNT_W = 8;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ALU    = 7'b0010011;

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] dbg_state;

    branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // expected event: {is_exception, cycles_asserted[7:0], address[31:0]}
    logic [40:0]      exp_q[$];
    logic [CNT_W-1:0] exp_branch_cnt = '0;
    logic [CNT_W-1:0] exp_taken_cnt  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // reference model: architectural rules for control transfers
    function automatic void model(input logic [6:0] op, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [31:0] rs1,
                                  input logic cond, output logic ctrl,
                                  output logic tk, output logic [31:0] tgt);
        ctrl = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
        tk   = ((op == OP_BRANCH) && cond) || (op == OP_JAL) || (op == OP_JALR);
        if (op == OP_JALR) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
        else               tgt = pc + imm;
    endfunction

    // driver tasks
    task automatic drive_idle();
        bus.ex_valid_i         = 1'b0;
        bus.stall_i            = 1'b0;
        bus.ex_opcode_i        = OP_ALU;
        bus.ex_pc_i            = 32'h0;
        bus.ex_imm_i           = 32'h0;
        bus.ex_rs1_i           = 32'h0;
        bus.branch_condition_i = 1'b0;
    endtask

    task automatic wrong_path(input logic stall);
        logic [6:0] ops[3];
        ops[0] = OP_BRANCH; ops[1] = OP_JAL; ops[2] = OP_JALR;
        bus.ex_valid_i         = 1'b1;
        bus.stall_i            = stall;
        bus.ex_opcode_i        = ops[$urandom_range(0, 2)];
        bus.ex_pc_i            = $urandom & 32'hFFFF_FFFC;
        bus.ex_imm_i           = $urandom & 32'h0000_0FFC;
        bus.ex_rs1_i           = $urandom & 32'hFFFF_FFFC;
        bus.branch_condition_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ex_valid_i         = 1'($urandom_range(0, 1));
            bus.stall_i            = bus.ex_valid_i ? 1'b1 : 1'($urandom_range(0, 1));
            bus.ex_opcode_i        = OP_JAL;
            bus.ex_pc_i            = $urandom;
            bus.ex_imm_i           = 32'h8;
            bus.branch_condition_i = 1'b1;
            @(posedge clk_i); #1;
        end
        drive_idle();
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic cond, input int stalls);
        logic        ctrl;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic [7:0]  dur;
        model(op, pc, imm, rs1, cond, ctrl, tk, tgt);
        mis = tgt[1];
        dur = mis ? 8'd1 : 8'(stalls + 1);
        if (tk) exp_q.push_back({mis, dur, tgt});
        bus.ex_valid_i         = 1'b1;
        bus.stall_i            = 1'b0;
        bus.ex_opcode_i        = op;
        bus.ex_pc_i            = pc;
        bus.ex_imm_i           = imm;
        bus.ex_rs1_i           = rs1;
        bus.branch_condition_i = cond;
        @(posedge clk_i); #1;
`ifdef BRANCH_PERF_EN
        if (ctrl) exp_branch_cnt = exp_branch_cnt + 1'b1;
        if (tk)   exp_taken_cnt  = exp_taken_cnt + 1'b1;
`endif
        if (tk && !mis) begin
            for (int i = 0; i < stalls; i++) wrong_path(1'b1);
            wrong_path(1'b0);
        end else if (tk) begin
            wrong_path(1'($urandom_range(0, 1)));
        end
        drive_idle();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        exp_branch_cnt = '0;
        exp_taken_cnt  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // scoreboard monitor
    logic        cur_active = 1'b0;
    logic        cur_kind;
    int          cur_rem;
    logic [31:0] cur_addr;
    logic [31:0] last_pc   = 32'h0;
    logic [31:0] last_addr = 32'h0;

    always @(negedge clk_i) begin
        logic [40:0] e;
        logic        ev;
        if (!rst_ni) begin
            check("rst_flags", {28'h0, bus.redirect_o, bus.flush_o, bus.ex_kill_o, bus.misalign_exc_o}, 32'h0);
            check("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
            check("rst_misalign_addr", bus.misalign_addr_o, 32'h0);
            check("rst_counters", {bus.branch_cnt_o, bus.taken_cnt_o}, 32'h0);
            cur_active = 1'b0;
            exp_q.delete();
            last_pc    = 32'h0;
            last_addr  = 32'h0;
        end else begin
            ev = bus.redirect_o | bus.misalign_exc_o;
            if (ev && !cur_active) begin
                check("event_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e          = exp_q.pop_front();
                    cur_kind   = e[40];
                    cur_rem    = int'(e[39:32]);
                    cur_addr   = e[31:0];
                    cur_active = 1'b1;
                end
            end
            if (cur_active) begin
                check("event_length", 32'(ev), 32'h1);
                if (ev) begin
                    check("redirect_o", 32'(bus.redirect_o), 32'(!cur_kind));
                    check("misalign_exc_o", 32'(bus.misalign_exc_o), 32'(cur_kind));
                    check("flush_o", 32'(bus.flush_o), 32'h1);
                    check("ex_kill_o", 32'(bus.ex_kill_o), 32'h1);
                    if (cur_kind) begin
                        check("misalign_addr_o", bus.misalign_addr_o, cur_addr);
                        check("held_redirect_pc", bus.redirect_pc_o, last_pc);
                        last_addr = cur_addr;
                    end else begin
                        check("redirect_pc_o", bus.redirect_pc_o, cur_addr);
                        check("held_misalign_addr", bus.misalign_addr_o, last_addr);
                        last_pc = cur_addr;
                    end
                    cur_rem--;
                    if (cur_rem == 0) cur_active = 1'b0;
                end else begin
                    cur_active = 1'b0;
                end
            end else if (!ev) begin
                check("idle_flush_kill", {30'h0, bus.flush_o, bus.ex_kill_o}, 32'h0);
                check("held_redirect_pc", bus.redirect_pc_o, last_pc);
                check("held_misalign_addr", bus.misalign_addr_o, last_addr);
            end
            check("branch_cnt_o", 32'(bus.branch_cnt_o), 32'(exp_branch_cnt));
            check("taken_cnt_o", 32'(bus.taken_cnt_o), 32'(exp_taken_cnt));
        end
    end

    // stimulus
    initial begin
        logic [6:0]  op;
        logic [31:0] imm;
        drive_idle();
        rst_ni = 1'b0;
        do_reset();

        issue(OP_BRANCH, 32'h100, 32'h20, 32'h0, 1'b1, 0);       // BEQ taken -> 0x120
        gap(2);
        issue(OP_BRANCH, 32'h200, 32'h40, 32'h0, 1'b0, 0);       // BNE not taken
        gap(2);
        issue(OP_JALR, 32'h0, 32'h4, 32'h1003, 1'b0, 3);         // target 0x1006 has bit1 set
        gap(1);
        issue(OP_JALR, 32'h0, 32'h4, 32'h1001, 1'b0, 3);         // target 0x1004, held by stall
        gap(1);
        issue(OP_JAL, 32'h300, 32'h2, 32'h0, 1'b0, 0);           // misaligned 0x302
        gap(1);
        issue(OP_BRANCH, 32'h400, 32'h80, 32'h0, 1'b1, 1);       // wrong-path taken ignored
        issue(OP_ALU, 32'h500, 32'h4, 32'h0, 1'b1, 0);

        // asynchronous reset in the middle of a stalled redirect
        bus.ex_valid_i         = 1'b1;
        bus.stall_i            = 1'b0;
        bus.ex_opcode_i        = OP_JAL;
        bus.ex_pc_i            = 32'h600;
        bus.ex_imm_i           = 32'h40;
        bus.branch_condition_i = 1'b0;
        exp_q.push_back({1'b0, 8'd1, 32'h640});
        @(posedge clk_i); #1;
        bus.stall_i = 1'b1;
        check("pre_reset_redirect", 32'(bus.redirect_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_flags", {28'h0, bus.redirect_o, bus.flush_o, bus.ex_kill_o, bus.misalign_exc_o}, 32'h0);
        check("async_reset_pc", bus.redirect_pc_o, 32'h0);
        drive_idle();
        do_reset();
        issue(OP_BRANCH, 32'h700, 32'h10, 32'h0, 1'b1, 0);       // resolved on first edge

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    op = OP_BRANCH;
                2:       op = OP_JAL;
                3:       op = OP_JALR;
                4:       op = OP_ALU;
                default: op = 7'($urandom);
            endcase
            imm = $urandom_range(0, 1) ? ($urandom & 32'h0000_1FFE) : (32'h0 - ($urandom & 32'h0000_1FFE));
            issue(op, $urandom & 32'hFFFF_FFFC, imm, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end

        // counter wrap: 256 taken JALs from a clean reset
        do_reset();
        for (int n = 0; n < 256; n++) issue(OP_JAL, 32'h800, 32'h8, 32'h0, 1'b0, 0);
        #1;
        check("taken_cnt_wrap", 32'(bus.taken_cnt_o), 32'(exp_taken_cnt));

        drive_idle();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || cur_active); i++) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("scoreboard_drained", 32'(exp_q.size()) + 32'(cur_active), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
